pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the four pipeline latches (FD, DE, EM, MW) of the 5-stage MIPS core.
//  Generates per-latch enable/flush, PC enable and halt from hit, hazard, branch and halt
//  inputs. Owns the dcache-wait / halt-drain FSM and a saturating stall counter.
//  Sits beside the datapath; its outputs gate the pipeline_regs_if latch writes.
// PARAMETERS
//  DRAIN_CYCLES  2   cycles held in DRAIN after a halt is seen in MEM (lets MW retire)
//  DWAIT_MAX     255 dcache-wait cycles before dwait_err sets
//  CNT_W         32  stall counter width
// PORTS
//  CLK            in   1     clock, all state updates on rising edge
//  nRST           in   1     asynchronous, active-low reset
//  ihit           in   1     icache returned instruction this cycle
//  dhit           in   1     dcache completed EM access this cycle
//  fd_rs, fd_rt   in   5     source regs of instruction in FD
//  fd_uses_rs/rt  in   1     FD instruction reads rs / rt
//  de_rt          in   5     DE_out.rt
//  de_load        in   1     DE_out.dcuREN && DE_out.regwr
//  em_memreq      in   1     EM_out.dcuREN || EM_out.dcuWEN
//  em_br_taken    in   1     branch/jump resolved taken in MEM
//  em_halt        in   1     instruction in MEM is HALT
//  pc_en          out  1     PC register load enable
//  fd_en, de_en, em_en, mw_en       out 1 each  latch enable (0 = hold)
//  fd_flush, de_flush, em_flush     out 1 each  latch loads zero/NOP this edge
//  halt           out  1     core halted (sticky until reset)
//  stall_cnt      out  CNT_W cycles with pc_en==0 while not HALTED, saturating
//  dwait_err      out  1     sticky: DWAIT exceeded DWAIT_MAX
// BEHAVIOUR
//  FSM states: RUN, DWAIT, DRAIN, HALTED; all outputs combinational from state+inputs
//  except halt, stall_cnt, dwait_err, drain/wait counters (registered).
//  Reset (nRST=0): state=RUN, halt=0, stall_cnt=0, dwait_err=0, counters=0.
//  Priority inside RUN/DWAIT (highest first):
//   1 dmem stall: em_memreq && !dhit -> all *_en=0, pc_en=0, no flushes;
//     RUN->DWAIT. DWAIT stays while !dhit; on dhit the same cycle is a normal
//     advance (rules 2-5 apply) and next state=RUN. dhit with em_memreq=0 ignored.
//   2 halt: em_halt -> pc_en=0, fd/de/em_flush=1, all en=1; next DRAIN, drain_cnt=0.
//   3 branch: em_br_taken -> pc_en=1 (target), fd/de/em_flush=1, all en=1.
//     Branch overrides load-use and ihit stalls in the same cycle.
//   4 load-use: de_load && de_rt!=0 && ((fd_uses_rs&&fd_rs==de_rt)||
//     (fd_uses_rt&&fd_rt==de_rt)) -> pc_en=0, fd_en=0, de_flush=1, em/mw advance.
//   5 ifetch miss: !ihit -> pc_en=0, fd_flush=1, others advance.
//   else all en=1, pc_en=1, no flushes.
//  Flush wins over enable: a flushed latch loads NOP even if en=1; flush with en=0 never
//  occurs.
//  DRAIN: pc_en=0, fd/de/em_flush=1, mw_en=1; drain_cnt++ each cycle; when
//   drain_cnt==DRAIN_CYCLES-1 next HALTED. dmem stall rule 1 still applies (freezes
//   drain_cnt).
//  HALTED: all en=0, pc_en=0, flushes 0, halt=1; exits only via nRST.
//  stall_cnt: +1 each cycle pc_en==0 in RUN/DWAIT/DRAIN; holds at 2^CNT_W-1.
//  dwait_err: wait_cnt counts consecutive DWAIT cycles, clears on leaving DWAIT; sets
//   when wait_cnt==DWAIT_MAX; sticky; no effect on sequencing.
//  Reset mid-DWAIT/DRAIN: immediate return to RUN, pending counts discarded.
// TESTING
//  T1 de_load, de_rt=8, fd_rs=8, fd_uses_rs, ihit=1 -> one cycle pc_en=0, fd_en=0,
//     de_flush=1; next cycle all en=1; stall_cnt=1.
//  T2 em_memreq=1, dhit low 3 cycles then high -> 3 cycles all en=0 in DWAIT, RUN on
//     4th; stall_cnt=3.
//  T3 em_br_taken with simultaneous load-use and ihit=0 -> pc_en=1,
//     fd/de/em_flush=1, no stall.
//  T4 em_halt (DRAIN_CYCLES=2) -> DRAIN 2 cycles, mw_en=1 only, then halt=1, all en=0
//     thereafter.
//  T5 dhit held 0 for 300 cycles, DWAIT_MAX=255 -> dwait_err rises after 255 DWAIT
//     cycles, stays 1 after dhit.
//  T6 nRST pulled low mid-DRAIN and mid-DWAIT -> state RUN, halt=0, stall_cnt=0
//     asynchronously.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: drives the FD/DE/EM/MW latch enables and flushes, the PC enable and halt.
// It also owns the dcache-wait/halt-drain FSM, the saturating stall counter and the dcache-timeout flag.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int DWAIT_MAX    = 255,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       fd_rs,
    input  logic [4:0]       fd_rt,
    input  logic             fd_uses_rs,
    input  logic             fd_uses_rt,
    input  logic [4:0]       de_rt,
    input  logic             de_load,
    input  logic             em_memreq,
    input  logic             em_br_taken,
    input  logic             em_halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             dwait_err
);
    localparam logic [1:0] RUN = 2'd0, DWAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3;
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WW = $clog2(DWAIT_MAX + 1);

    logic [1:0]    state, state_nxt;
    logic [DW-1:0] drain_cnt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          dstall, load_use;

    assign dstall   = em_memreq && !dhit;
    assign load_use = de_load && de_rt != 5'd0 &&
                      ((fd_uses_rs && fd_rs == de_rt) || (fd_uses_rt && fd_rt == de_rt));
    assign wait_nxt = state != DWAIT ? '0 :
                      wait_cnt == WW'(DWAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

    always_comb begin
        {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush} = 8'b0;
        state_nxt = state;
        if (state == HALTED || dstall) begin
            state_nxt = state == RUN ? DWAIT : state;
        end else if (state == DRAIN) begin
            {fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush} = 7'b1111_111;
            state_nxt = drain_cnt == DW'(DRAIN_CYCLES - 1) ? HALTED : DRAIN;
        end else begin
            // Priority: halt > taken branch > load-use > icache miss.
            state_nxt = em_halt ? DRAIN : RUN;
            {fd_en, de_en, em_en, mw_en} = 4'hf;
            if (em_halt) begin
                {fd_flush, de_flush, em_flush} = 3'b111;
            end else if (em_br_taken) begin
                pc_en = 1'b1;
                {fd_flush, de_flush, em_flush} = 3'b111;
            end else if (load_use) begin
                fd_en    = 1'b0;
                de_flush = 1'b1;
            end else if (!ihit) begin
                fd_flush = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            drain_cnt <= '0;
            wait_cnt  <= '0;
            halt      <= 1'b0;
            stall_cnt <= '0;
            dwait_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= state != DRAIN ? '0 : dstall ? drain_cnt : drain_cnt + 1'b1;
            wait_cnt  <= wait_nxt;
            dwait_err <= dwait_err || wait_nxt == WW'(DWAIT_MAX);
            halt      <= halt || state_nxt == HALTED;
            stall_cnt <= (!pc_en && state != HALTED && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus for pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;
    localparam int DC = 2, DM = 255, CW = 8, CMAX = 255;

    logic CLK = 1'b0, nRST = 1'b0;
    logic ihit, dhit, fd_uses_rs, fd_uses_rt, de_load, em_memreq, em_br_taken, em_halt;
    logic [4:0] fd_rs, fd_rt, de_rt;
    logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, halt, dwait_err;
    logic [CW-1:0] stall_cnt;
    logic [7:0] got_o;

    int checks = 0, errors = 0;
    bit m_halted, m_drain, m_wait, m_err;
    int m_dn, m_wrun, m_stall;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .DWAIT_MAX(DM), .CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .de_rt(de_rt), .de_load(de_load),
        .em_memreq(em_memreq), .em_br_taken(em_br_taken), .em_halt(em_halt),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .halt(halt),
        .stall_cnt(stall_cnt), .dwait_err(dwait_err)
    );

    always #5 CLK = ~CLK;
    assign got_o = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush};

    // Expected {pc_en, fd/de/em/mw_en, fd/de/em_flush} straight from the priority rules.
    function automatic logic [7:0] expect_outs();
        logic lu;
        lu = de_load && de_rt != 0 &&
             ((fd_uses_rs && fd_rs == de_rt) || (fd_uses_rt && fd_rt == de_rt));
        if (m_halted || (em_memreq && !dhit)) return 8'b0_0000_000;
        if (m_drain || em_halt) return 8'b0_1111_111;
        if (em_br_taken) return 8'b1_1111_111;
        if (lu) return 8'b0_0111_010;
        if (!ihit) return 8'b0_1111_100;
        return 8'b1_1111_000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit ih, input bit dh, input bit mr, input bit br, input bit eh,
                         input bit dl, input logic [4:0] drt, input logic [4:0] frs,
                         input logic [4:0] frt, input bit urs, input bit urt);
        ihit = ih; dhit = dh; em_memreq = mr; em_br_taken = br; em_halt = eh;
        de_load = dl; de_rt = drt; fd_rs = frs; fd_rt = frt; fd_uses_rs = urs; fd_uses_rt = urt;
    endtask

    task automatic idle();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step(input string tag);
        logic [7:0] e;
        @(negedge CLK);
        e = expect_outs();
        check({tag, " outs"}, got_o, e);
        if (!m_halted) begin
            if (!e[7]) m_stall = m_stall < CMAX ? m_stall + 1 : CMAX;
            if (m_wait) begin
                m_wrun = m_wrun < DM ? m_wrun + 1 : DM;
                if (m_wrun == DM) m_err = 1;
            end else m_wrun = 0;
            if (em_memreq && !dhit) begin
                if (!m_drain) m_wait = 1;
            end else if (m_drain) begin
                m_dn++;
                if (m_dn == DC) begin m_halted = 1; m_drain = 0; end
            end else begin
                m_wait = 0;
                if (em_halt) begin m_drain = 1; m_dn = 0; end
            end
        end
        @(posedge CLK);
        #1;
        check({tag, " halt"}, halt, m_halted);
        check({tag, " stall_cnt"}, stall_cnt, m_stall);
        check({tag, " dwait_err"}, dwait_err, m_err);
    endtask

    // Called just after a rising edge; the whole pulse sits between edges.
    task automatic do_reset(input string tag);
        nRST = 1'b0;
        #1;
        m_halted = 0; m_drain = 0; m_wait = 0; m_err = 0; m_dn = 0; m_wrun = 0; m_stall = 0;
        check({tag, " halt"}, halt, 0);
        check({tag, " stall_cnt"}, stall_cnt, 0);
        check({tag, " dwait_err"}, dwait_err, 0);
        check({tag, " outs"}, got_o, expect_outs());
        #2;
        nRST = 1'b1;
    endtask

    initial begin
        idle();
        @(posedge CLK);
        #1;
        do_reset("rst0");
        check("rst0 run", got_o, 8'hF8);
        step("idle");
        // T1 load-use
        drive(1, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 1, 0);
        step("t1_lu");
        idle();
        step("t1_adv");
        check("t1 stall_cnt", stall_cnt, 1);
        // T2 dcache wait of three cycles
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step("t2_wait");
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("t2_hit");
        check("t2 stall_cnt", stall_cnt, 4);
        // T3 branch beats load-use and icache miss
        drive(0, 1, 0, 1, 0, 1, 5'd8, 5'd8, 5'd8, 1, 1);
        step("t3_br");
        check("t3 stall_cnt", stall_cnt, 4);
        idle();
        step("t3_adv");
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            step("rand");
        end
        // T5 long dcache wait, stall counter saturation
        idle();
        @(posedge CLK);
        #1;
        do_reset("t5_rst");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (300) step("t5_wait");
        check("t5 err", dwait_err, 1);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("t5_hit");
        idle();
        step("t5_adv");
        check("t5 err sticky", dwait_err, 1);
        check("t5 stall sat", stall_cnt, CMAX);
        // T6 reset during DWAIT then during DRAIN
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step("t6_wait");
        do_reset("t6_dwait_rst");
        drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("t6_halt");
        idle();
        step("t6_drain");
        do_reset("t6_drain_rst");
        check("t6 run", got_o, 8'hF8);
        // T4 halt drain, one frozen drain cycle, then HALTED
        drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("t4_halt");
        idle();
        step("t4_drain0");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("t4_drain_frz");
        idle();
        step("t4_drain1");
        check("t4 halt", halt, 1);
        check("t4 stall_cnt", stall_cnt, 4);
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, $urandom_range(0, 1) == 1, 1, 0, 0, 0, 0, 0, 0);
            step("t4_halted");
        end
        check("t4 halted outs", got_o, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
